// File: rtl/fir_mac_serial.sv
// Time-multiplexed FIR engine: circular delay line, one shared multiplier, one output per sample.
// Optional macro FIR_SAT_EN clamps the shifted accumulator to the output range instead of wrapping.
module fir_mac_serial #(
    parameter int NBADD = 8,
    parameter int NBITS = 16,
    parameter int NTAPS = 96,
    parameter int DW    = 12,
    parameter int SHIFT = 13,
    parameter int OUTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic [DW-1:0]    din,
    output logic [NBADD-1:0] coeff_addr,
    input  logic [NBITS:0]   coeff,
    output logic             dout_valid,
    output logic [OUTW-1:0]  dout,
    output logic             busy,
    output logic             overrun
);

    localparam int PW   = DW + NBITS + 1;
    localparam int ACCW = PW + $clog2(NTAPS);
    localparam int PTRW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int EXTW = ACCW + OUTW;

    localparam logic [PTRW-1:0]  LAST_PTR = PTRW'(NTAPS - 1);
    localparam logic [NBADD-1:0] LAST_TAP = NBADD'(NTAPS - 1);

`ifdef FIR_SAT_EN
    localparam logic signed [EXTW-1:0] SAT_MAX = {{(EXTW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}};
    localparam logic signed [EXTW-1:0] SAT_MIN = {{(EXTW-OUTW+1){1'b1}}, {(OUTW-1){1'b0}}};
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t                  state;
    logic signed [DW-1:0]    mem [NTAPS];
    logic [PTRW-1:0]         wr_ptr;
    logic [PTRW-1:0]         rd_ptr;
    logic signed [ACCW-1:0]  acc;
    logic signed [PW-1:0]    prod_p1;
    logic                    vld_p1;

    logic                    accept;
    logic signed [ACCW-1:0]  acc_sum;
    logic signed [DW-1:0]    tap_x;
    logic signed [NBITS:0]   tap_c;

    function automatic logic signed [OUTW-1:0] fmt_out(input logic signed [ACCW-1:0] a);
        logic signed [EXTW-1:0] s;
        s = EXTW'(a) >>> SHIFT;
`ifdef FIR_SAT_EN
        if (s > SAT_MAX)
            s = SAT_MAX;
        else if (s < SAT_MIN)
            s = SAT_MIN;
`endif
        return s[OUTW-1:0];
    endfunction

    always_comb begin
        accept  = din_valid && (state == IDLE || state == OUT);
        tap_x   = mem[rd_ptr];
        tap_c   = $signed(coeff);
        acc_sum = acc + (vld_p1 ? ACCW'(prod_p1) : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            for (int i = 0; i < NTAPS; i++)
                mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            acc        <= '0;
            prod_p1    <= '0;
            vld_p1     <= 1'b0;
            coeff_addr <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun    <= din_valid && (state == RUN || state == DRAIN);
            dout_valid <= 1'b0;
            case (state)
                IDLE, OUT: begin
                    if (accept) begin
                        mem[wr_ptr] <= $signed(din);
                        rd_ptr      <= wr_ptr;
                        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
                        coeff_addr  <= '0;
                        acc         <= '0;
                        vld_p1      <= 1'b0;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                // multiply stage feeds prod_p1; accumulate stage lags it by one cycle
                RUN: begin
                    prod_p1 <= PW'(tap_x) * PW'(tap_c);
                    vld_p1  <= 1'b1;
                    acc     <= acc_sum;
                    rd_ptr  <= (rd_ptr == '0) ? LAST_PTR : rd_ptr - 1'b1;
                    if (coeff_addr == LAST_TAP) begin
                        coeff_addr <= '0;
                        state      <= DRAIN;
                    end else begin
                        coeff_addr <= coeff_addr + 1'b1;
                    end
                end
                // final product folds in here; output is formatted from the completed sum
                DRAIN: begin
                    acc        <= acc_sum;
                    dout       <= fmt_out(acc_sum);
                    dout_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= OUT;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_serial.sv
// Scoreboard bench for fir_mac_serial: three instances (full width, 16-bit unshifted, default shift)
// share one stimulus stream; a behavioural delay-line model predicts every output.
module tb_fir_mac_serial;

    localparam int NTAPS = 96;
    localparam int ACCW  = 12 + 16 + 1 + $clog2(NTAPS);
`ifdef FIR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            din_valid = 1'b0;
    logic [11:0]     din = '0;

    logic [7:0]      addr_a, addr_b, addr_c;
    logic [16:0]     coef_a, coef_b, coef_c;
    logic            dv_a, dv_b, dv_c;
    logic [ACCW-1:0] dout_a;
    logic [15:0]     dout_b, dout_c;
    logic            busy_a, busy_b, busy_c;
    logic            ovr_a, ovr_b, ovr_c;

    int     n_vec = 0;
    int     n_err = 0;
    int     n_ovr = 0;
    longint sb[$];
    int     hist[NTAPS];
    int     wptr = 0;

    always #5 clk = ~clk;

    function automatic int coef(int k);
        int j;
        j = (k > 47) ? 95 - k : k;
        case (j)
            0:       return 16;
            1:       return 14;
            2:       return -24;
            3:       return -92;
            47:      return 3825;
            default: return 80 * j - ((j % 5 == 0) ? 900 : 0);
        endcase
    endfunction

    function automatic logic [16:0] rom(logic [7:0] a);
        if (int'(a) >= NTAPS)
            return '0;
        return 17'(coef(int'(a)));
    endfunction

    assign coef_a = rom(addr_a);
    assign coef_b = rom(addr_b);
    assign coef_c = rom(addr_c);

    fir_mac_serial #(.SHIFT(0), .OUTW(ACCW)) dut_a (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
        .coeff_addr(addr_a), .coeff(coef_a), .dout_valid(dv_a), .dout(dout_a),
        .busy(busy_a), .overrun(ovr_a));

    fir_mac_serial #(.SHIFT(0), .OUTW(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
        .coeff_addr(addr_b), .coeff(coef_b), .dout_valid(dv_b), .dout(dout_b),
        .busy(busy_b), .overrun(ovr_b));

    fir_mac_serial dut_c (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
        .coeff_addr(addr_c), .coeff(coef_c), .dout_valid(dv_c), .dout(dout_c),
        .busy(busy_c), .overrun(ovr_c));

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint fmt(longint v, int sh, int ow);
        longint s, mx, mn;
        s  = v >>> sh;
        mx = (longint'(1) << (ow - 1)) - 1;
        mn = -mx - 1;
        if (SAT) begin
            if (s > mx) s = mx;
            if (s < mn) s = mn;
        end else begin
            s = (s << (64 - ow)) >>> (64 - ow);
        end
        return s;
    endfunction

    task automatic model_accept(input int x);
        longint sum;
        hist[wptr] = x;
        sum = 0;
        for (int k = 0; k < NTAPS; k++)
            sum += longint'(hist[(wptr - k + NTAPS) % NTAPS]) * longint'(coef(k));
        sb.push_back(sum);
        wptr = (wptr + 1) % NTAPS;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NTAPS; i++)
            hist[i] = 0;
        wptr = 0;
        sb.delete();
    endtask

    // Drive one sample; the next call lands exactly gap cycles later.
    task automatic send(input int x, input int gap);
        @(negedge clk);
        din = 12'(x);
        din_valid = 1'b1;
        model_accept(x);
        @(negedge clk);
        din_valid = 1'b0;
        din = '0;
        repeat (gap - 2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && ovr_a)
            n_ovr++;
        if (rst_n && dv_a) begin
            check("dv_lockstep", {dv_b, dv_c}, 2'b11);
            if (sb.size() == 0) begin
                check("spurious_dout_valid", 1, 0);
            end else begin
                longint e;
                e = sb.pop_front();
                check("dout_full", $signed(dout_a), e);
                check("dout_16", $signed(dout_b), fmt(e, 0, 16));
                check("dout_shift13", $signed(dout_c), fmt(e, 13, 16));
            end
        end
    end

    initial begin
        int busy_cnt, dv_pos, dv_cnt, first_busy, waited;
        model_clear();

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dout", dout_a, 0);
        check("rst_dout_valid", dv_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_overrun", ovr_a, 0);
        check("rst_coeff_addr", addr_a, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // latency from an IDLE accept
        din = 12'(1000);
        din_valid = 1'b1;
        model_accept(1000);
        busy_cnt = 0; dv_pos = -1; dv_cnt = 0; first_busy = -1;
        for (int i = 0; i < 110; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                din_valid = 1'b0;
                din = '0;
            end
            if (busy_a) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = 11 + i;
            end
            if (dv_a) begin
                dv_cnt++;
                dv_pos = 11 + i;
            end
        end
        check("lat_busy_first_cycle", first_busy, 11);
        check("lat_busy_cycles", busy_cnt, NTAPS + 1);
        check("lat_dv_cycle", dv_pos, 108);
        check("lat_dv_count", dv_cnt, 1);

        // impulse, back-to-back at minimum spacing
        send(1000, 98);
        for (int i = 0; i < 95; i++) send(0, 98);

        // DC step
        for (int i = 0; i < 100; i++) send(100, 98);

        // saturation / wrap at both extremes
        for (int i = 0; i < 96; i++) send(2047, 98);
        for (int i = 0; i < 96; i++) send(-2048, 98);

        // overrun: a second strobe five cycles after accept is dropped
        send(500, 5);
        @(negedge clk);
        din = 12'(1234);
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        din = '0;
        check("overrun_pulse", ovr_a, 1);
        check("overrun_wr_ptr", dut_a.wr_ptr, wptr);
        check("overrun_busy", busy_a, 1);
        repeat (100) @(negedge clk);
        send(-300, 98);

        // reset mid-RUN aborts the computation
        @(negedge clk);
        din = 12'(777);
        din_valid = 1'b1;
        model_accept(777);
        @(negedge clk);
        din_valid = 1'b0;
        din = '0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        check("abort_busy", busy_a, 0);
        check("abort_dout", dout_a, 0);
        check("abort_dout_valid", dv_a, 0);
        check("abort_coeff_addr", addr_a, 0);
        check("abort_acc", dut_a.acc, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dv_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dv_a) dv_cnt++;
        end
        check("abort_no_dout_valid", dv_cnt, 0);

        // pointer wrap, then a clean impulse
        for (int i = 0; i < 200; i++) send(0, 98);
        send(1000, 98);
        for (int i = 0; i < 95; i++) send(0, 98);

        waited = 0;
        while (sb.size() != 0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("scoreboard_drained", sb.size(), 0);
        check("overrun_total", n_ovr, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
